// File: rtl/issue_controller_if.sv
// issue_controller_if: fetch, resource-availability and issue signals of
// the in-order issue sequencer, bundled so they can be passed as one port.
//   master : drives the fetch stream, the reservation-station/ROB free flags,
//            flush and br_resolve, and observes fetch_ready and issue outputs
//   slave  : the issue_controller side
interface issue_controller_if;
  logic        fetch_valid;
  logic [31:0] fetch_instr;
  logic        fetch_ready;
  logic        rob_free;
  logic        alu_free;
  logic        mul_free;
  logic        mem_free;
  logic        flush;
  logic        br_resolve;
  logic        issue_valid;
  logic [31:0] issue_instr;
  logic [1:0]  issue_class;
  logic        stall;

  modport master (
    output fetch_valid, fetch_instr, rob_free, alu_free, mul_free, mem_free,
           flush, br_resolve,
    input  fetch_ready, issue_valid, issue_instr, issue_class, stall
  );

  modport slave (
    input  fetch_valid, fetch_instr, rob_free, alu_free, mul_free, mem_free,
           flush, br_resolve,
    output fetch_ready, issue_valid, issue_instr, issue_class, stall
  );
endinterface

// File: rtl/issue_controller.sv
// issue_controller: in-order issue sequencer between fetch and decode.
// Buffers fetched words in a DEPTH-entry circular queue, classifies the head
// word by functional unit and issues at most one word per cycle when the ROB
// and the target reservation station both have room. issue_valid is the
// registered one-cycle strobe that drives decodePulse.
// Ports:
//   clock  : rising-edge clock
//   rst_n  : asynchronous active-low reset
//   bus    : issue_controller_if.slave (fetch handshake, free flags, flush,
//            br_resolve, issue_valid/instr/class, stall)
// Optional feature macro ISSUE_BNE_BLOCK_EN: after a bne issues, hold all
// further issue until br_resolve or flush.
module issue_controller #(
  parameter int unsigned DEPTH = 4
) (
  input logic               clock,
  input logic               rst_n,
  issue_controller_if.slave bus
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  typedef enum logic [1:0] {
    ST_EMPTY   = 2'd0,
    ST_READY   = 2'd1,
    ST_WAIT_BR = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    CL_ALU = 2'd0,
    CL_MUL = 2'd1,
    CL_MEM = 2'd2,
    CL_BR  = 2'd3
  } class_t;

  logic [31:0]   mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  state_t        state_q, state_d;
  logic          issue_valid_q, issue_valid_d;
  logic [31:0]   issue_instr_q, issue_instr_d;
  class_t        issue_class_q, issue_class_d;

  logic [31:0] head;
  logic [5:0]  opcode, funct;
  class_t      head_class;
  logic        head_legal;
  logic        head_valid;
  logic        full;
  logic        unit_free;
  logic        wait_br;
  logic        fetch_ready;
  logic        push, pop, issue, drop;

  assign head       = mem_q[rd_ptr_q];
  assign opcode     = head[31:26];
  assign funct      = head[5:0];
  assign head_valid = (count_q != '0);
  assign full       = (count_q == CW'(DEPTH));

  always_comb begin
    head_legal = 1'b1;
    head_class = CL_ALU;
    case (opcode)
      6'b000000: head_legal = (funct == 6'b100000) || (funct == 6'b100010) ||
                              (funct == 6'b000000) || (funct == 6'b000010);
      6'b001000,
      6'b110000: head_class = CL_ALU;
      6'b011100: begin
        head_class = CL_MUL;
        head_legal = (funct == 6'b000010);
      end
      6'b100011,
      6'b101011: head_class = CL_MEM;
      6'b000101: head_class = CL_BR;
      default:   head_legal = 1'b0;
    endcase
  end

  always_comb begin
    unit_free = 1'b0;
    case (head_class)
      CL_ALU, CL_BR: unit_free = bus.alu_free;
      CL_MUL:        unit_free = bus.mul_free;
      CL_MEM:        unit_free = bus.mem_free;
      default:       unit_free = 1'b0;
    endcase
  end

`ifdef ISSUE_BNE_BLOCK_EN
  assign wait_br = (state_q == ST_WAIT_BR);
`else
  assign wait_br = 1'b0;
`endif

  // Full-based only: a pop in the same cycle does not reopen the queue.
  assign fetch_ready = !full && !bus.flush;
  assign push        = bus.fetch_valid && fetch_ready;
  assign issue = head_valid && head_legal && bus.rob_free && unit_free &&
                 !wait_br && !bus.flush;
  // Illegal heads are discarded in one cycle; the branch block also holds them.
  assign drop  = head_valid && !head_legal && !wait_br && !bus.flush;
  assign pop   = issue || drop;

  always_comb begin
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    count_d       = count_q;
    state_d       = state_q;
    issue_valid_d = issue;
    issue_instr_d = issue ? head : issue_instr_q;
    issue_class_d = issue ? head_class : issue_class_q;

    if (bus.flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      state_d  = ST_EMPTY;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase

      state_d = (count_d != '0) ? ST_READY : ST_EMPTY;
`ifdef ISSUE_BNE_BLOCK_EN
      // br_resolve only matters once in WAIT_BR, so a resolve coinciding
      // with the bne issue itself is ignored.
      if (state_q == ST_WAIT_BR) begin
        if (!bus.br_resolve) state_d = ST_WAIT_BR;
      end else if (issue && head_class == CL_BR) begin
        state_d = ST_WAIT_BR;
      end
`endif
    end
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      state_q       <= ST_EMPTY;
      issue_valid_q <= 1'b0;
      issue_instr_q <= '0;
      issue_class_q <= CL_ALU;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      state_q       <= state_d;
      issue_valid_q <= issue_valid_d;
      issue_instr_q <= issue_instr_d;
      issue_class_q <= issue_class_d;
    end
  end

  // Queue storage carries no reset; count_q alone defines which entries are live.
  always_ff @(posedge clock) begin
    if (push) mem_q[wr_ptr_q] <= bus.fetch_instr;
  end

  assign bus.fetch_ready = fetch_ready;
  assign bus.issue_valid = issue_valid_q;
  assign bus.issue_instr = issue_instr_q;
  assign bus.issue_class = issue_class_q;
  assign bus.stall       = head_valid && !issue && !drop;

endmodule

// File: tb/tb_issue_controller.sv
module tb_issue_controller;

  localparam logic [31:0] ADD0 = 32'h01095020;
  localparam logic [31:0] MUL0 = 32'h71095002;
  localparam logic [31:0] ILL0 = 32'hFC000000;
  localparam logic [31:0] BNE0 = 32'h15090003;

  logic clock = 1'b0;
  logic rst_n = 1'b0;
  always #5 clock = ~clock;

  issue_controller_if bus();

  issue_controller #(.DEPTH(4)) dut (
    .clock (clock),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int unsigned checks  = 0;
  int unsigned errors  = 0;
  int unsigned n_strobe = 0;
  logic [33:0] sb [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: every strobe must match the oldest expected word.
  always @(negedge clock) begin
    if (rst_n && bus.issue_valid === 1'b1) begin
      logic [33:0] e;
      n_strobe++;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_issue: got instr %h with no expected entry at %0t",
                 bus.issue_instr, $time);
      end else begin
        e = sb.pop_front();
        chk("sb_instr", bus.issue_instr, e[33:2]);
        chk("sb_class", 32'(bus.issue_class), 32'(e[1:0]));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1);
  end

  task automatic align();
    @(posedge clock);
    #1;
  endtask

  task automatic push(input logic [31:0] w, input logic [1:0] cls, input bit expect_issue);
    bus.fetch_valid = 1'b1;
    bus.fetch_instr = w;
    if (expect_issue) sb.push_back({w, cls});
    @(posedge clock);
    #1;
    bus.fetch_valid = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_issue_valid"}, 32'(bus.issue_valid), 32'd0);
    chk({tag, "_issue_instr"}, bus.issue_instr, 32'd0);
    chk({tag, "_issue_class"}, 32'(bus.issue_class), 32'd0);
    chk({tag, "_stall"}, 32'(bus.stall), 32'd0);
    chk({tag, "_fetch_ready"}, 32'(bus.fetch_ready), 32'd1);
  endtask

  int unsigned s0;

  initial begin
    bus.fetch_valid = 1'b0;
    bus.fetch_instr = '0;
    bus.rob_free    = 1'b1;
    bus.alu_free    = 1'b1;
    bus.mul_free    = 1'b1;
    bus.mem_free    = 1'b1;
    bus.flush       = 1'b0;
    bus.br_resolve  = 1'b0;

    // Reset values
    repeat (2) @(negedge clock);
    chk_reset_outputs("reset");
    align();
    rst_n = 1'b1;
    align();

    // Single add: strobe exactly one cycle after the push edge
    push(ADD0, 2'd0, 1'b1);
    @(negedge clock);
    chk("no_bypass", 32'(bus.issue_valid), 32'd0);
    chk("add_no_stall", 32'(bus.stall), 32'd0);
    @(negedge clock);
    chk("add_issue_valid", 32'(bus.issue_valid), 32'd1);
    chk("add_issue_instr", bus.issue_instr, ADD0);
    chk("add_issue_class", 32'(bus.issue_class), 32'd0);
    @(negedge clock);
    chk("single_strobe", 32'(bus.issue_valid), 32'd0);

    // Fill the queue with the ROB full, then drain back-to-back
    align();
    bus.rob_free = 1'b0;
    push(32'h00221820, 2'd0, 1'b1);
    push(32'h00432022, 2'd0, 1'b1);
    push(32'h00641000, 2'd0, 1'b1);
    push(32'h20050007, 2'd0, 1'b1);
    @(negedge clock);
    chk("full_ready", 32'(bus.fetch_ready), 32'd0);
    chk("full_stall", 32'(bus.stall), 32'd1);
    chk("full_no_issue", 32'(bus.issue_valid), 32'd0);
    align();
    bus.rob_free = 1'b1;
    @(negedge clock);
    chk("full_pop_ready", 32'(bus.fetch_ready), 32'd0);
    chk("full_pop_stall", 32'(bus.stall), 32'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      chk("drain_burst", 32'(bus.issue_valid), 32'd1);
    end
    @(negedge clock);
    chk("drain_done_valid", 32'(bus.issue_valid), 32'd0);
    chk("drain_done_ready", 32'(bus.fetch_ready), 32'd1);
    chk("drain_done_stall", 32'(bus.stall), 32'd0);

    // MUL blocked at head; the following add must not overtake it
    align();
    bus.mul_free = 1'b0;
    push(MUL0, 2'd1, 1'b1);
    push(ADD0, 2'd0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      chk("mul_blocked_valid", 32'(bus.issue_valid), 32'd0);
      chk("mul_blocked_stall", 32'(bus.stall), 32'd1);
    end
    align();
    bus.mul_free = 1'b1;
    repeat (4) @(negedge clock);

    // Illegal word is dropped silently; the add behind it issues next
    align();
    bus.fetch_valid = 1'b1;
    bus.fetch_instr = ILL0;
    @(posedge clock);
    #1;
    bus.fetch_instr = ADD0;
    sb.push_back({ADD0, 2'd0});
    @(negedge clock);
    chk("illegal_no_stall", 32'(bus.stall), 32'd0);
    chk("illegal_no_issue", 32'(bus.issue_valid), 32'd0);
    @(posedge clock);
    #1;
    bus.fetch_valid = 1'b0;
    @(negedge clock);
    chk("illegal_drop_cycle", 32'(bus.issue_valid), 32'd0);
    @(negedge clock);
    chk("add_after_illegal", 32'(bus.issue_valid), 32'd1);

    // bne followed by three adds
    repeat (2) @(negedge clock);
    align();
    s0 = n_strobe;
    push(BNE0, 2'd3, 1'b1);
    push(ADD0, 2'd0, 1'b1);
    push(32'h00221820, 2'd0, 1'b1);
    push(32'h00432022, 2'd0, 1'b1);
`ifdef ISSUE_BNE_BLOCK_EN
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      chk("wait_br_no_issue", 32'(bus.issue_valid), 32'd0);
      chk("wait_br_stall", 32'(bus.stall), 32'd1);
    end
    chk("wait_br_strobes", n_strobe - s0, 32'd1);
    align();
    bus.br_resolve = 1'b1;
    align();
    bus.br_resolve = 1'b0;
    @(negedge clock);
    chk("resolve_cycle", 32'(bus.issue_valid), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      chk("after_resolve_burst", 32'(bus.issue_valid), 32'd1);
    end
    @(negedge clock);
    chk("after_resolve_done", 32'(bus.issue_valid), 32'd0);
    chk("bne_strobes", n_strobe - s0, 32'd4);
`else
    @(negedge clock);
    chk("bne_backtoback_a", 32'(bus.issue_valid), 32'd1);
    @(negedge clock);
    chk("bne_backtoback_b", 32'(bus.issue_valid), 32'd1);
    @(negedge clock);
    chk("bne_done", 32'(bus.issue_valid), 32'd0);
    chk("bne_strobes", n_strobe - s0, 32'd4);
`endif

    // Flush with three queued entries
    align();
    bus.rob_free = 1'b0;
    push(ADD0, 2'd0, 1'b0);
    push(MUL0, 2'd1, 1'b0);
    push(ADD0, 2'd0, 1'b0);
    bus.flush    = 1'b1;
    bus.rob_free = 1'b1;
    @(negedge clock);
    chk("flush_ready", 32'(bus.fetch_ready), 32'd0);
    align();
    bus.flush = 1'b0;
    @(negedge clock);
    chk("flush_no_issue", 32'(bus.issue_valid), 32'd0);
    chk("flush_ready_after", 32'(bus.fetch_ready), 32'd1);
    chk("flush_empty", 32'(bus.stall), 32'd0);
    repeat (2) begin
      @(negedge clock);
      chk("flush_quiet", 32'(bus.issue_valid), 32'd0);
    end

    // Asynchronous reset mid-stream
    align();
    push(ADD0, 2'd0, 1'b1);
    push(32'h20050007, 2'd0, 1'b1);
    @(negedge clock);
    chk("pre_reset_issue", 32'(bus.issue_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("async_reset");
    sb.delete();
    align();
    rst_n = 1'b1;
    @(negedge clock);
    chk("post_reset_valid", 32'(bus.issue_valid), 32'd0);
    chk("post_reset_stall", 32'(bus.stall), 32'd0);
    align();
    push(32'h8C220004, 2'd2, 1'b1);
    repeat (3) @(negedge clock);

    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/issue_controller.md
# issue_controller

In-order issue sequencer between the fetch stage and `instructionDecode`. It buffers fetched instruction words in a small queue and classifies each head instruction by functional unit. It issues exactly one instruction per cycle only when both the ROB and the target reservation station have room, and it produces the registered one-cycle strobe that drives `decodePulse`. Branch flushes empty the queue.

## Interface
- `DEPTH`, 4: instruction queue entries; power of two, ≥2.
- `clock`  in  1  system clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `fetch_valid`  in  1  fetch presents `fetch_instr` this cycle.
- `fetch_instr`  in  32  MIPS-encoded instruction word.
- `fetch_ready`  out  1  queue accepts a word; = !full && !flush.
- `rob_free`  in  1  ROB has at least one free entry.
- `alu_free`  in  1  ALU/branch reservation station has a free slot.
- `mul_free`  in  1  multiplier reservation station has a free slot.
- `mem_free`  in  1  load/store reservation station has a free slot.
- `flush`  in  1  mispredict; clears the queue and the branch block.
- `br_resolve`  in  1  outstanding `bne` resolved (used only with BNE_BLOCK_EN).
- `issue_valid`  out  1  one-cycle issue strobe; connects to `decodePulse`.
- `issue_instr`  out  32  issued word; stable until the next issue.
- `issue_class`  out  2  0=ALU, 1=MUL, 2=MEM, 3=BR.
- `stall`  out  1  head is valid but was not issued this cycle.

## Operation
- The queue is a circular FIFO with `DEPTH` entries. It has read and write pointers of `$clog2(DEPTH)` bits and a count of `$clog2(DEPTH)+1` bits. Pointers wrap modulo `DEPTH`.
- A push occurs when `fetch_valid && fetch_ready`. A pop occurs on issue or on a drop. Push and pop in the same cycle leave the count unchanged.
- Classification is combinational on the head word:
  - ALU: opcode 000000 with funct 100000, 100010, 000000 or 000010; opcode 001000 (addi); opcode 110000 (li).
  - MUL: opcode 011100 with funct 000010.
  - MEM: opcode 100011 or 101011.
  - BR: opcode 000101.
  - Anything else is illegal.
- The unit check uses `alu_free` for both ALU and BR, `mul_free` for MUL, and `mem_free` for MEM.
- Issue condition: head valid && `rob_free` && unit free && state != WAIT_BR && !`flush`.
- An illegal head is popped without issue, taking one cycle. It produces no `issue_valid` and no `stall`.
- State machine:
  - EMPTY: count==0. Goes to READY on push.
  - READY: head valid. On issue, goes to EMPTY if the resulting count is 0, otherwise stays in READY. On a failed issue condition it stays in READY and `stall`=1.
  - WAIT_BR (BNE_BLOCK_EN only): entered after issuing BR. Exits on `br_resolve` or `flush` to READY or EMPTY according to count.
- Flush: the pointers and count clear on the next edge. `issue_valid` is 0 in the flush cycle. The state goes to EMPTY. A push is impossible in that cycle because `fetch_ready`=0.
- `br_resolve` received in the same cycle as a BR issue is ignored.

## Timing
- Reset values: `issue_valid`=0, `issue_instr`=0, `issue_class`=0, `stall`=0, `fetch_ready`=1, count=0, state EMPTY.
- Latency: a word pushed at edge N is eligible at edge N+1, so `issue_valid` is high during cycle N+1→N+2 at the earliest. There is no bypass from fetch to issue.
- `issue_valid`, `issue_instr` and `issue_class` are registered. `issue_valid` is never high for two consecutive cycles for the same word.
- Sustained throughput is 1 issue per cycle when all frees are high.
- `stall` and `fetch_ready` are combinational from the current state and inputs.
- Full queue: `fetch_ready`=0. A simultaneous pop does not reopen `fetch_ready` within that cycle.
- Reset asserted mid-operation clears everything immediately and asynchronously. The first issue is possible only after a push following reset release.

## Configuration
- `ISSUE_BNE_BLOCK_EN` defined:
  - After a BR issue, the controller enters WAIT_BR and holds all further issue until `br_resolve` or `flush`.
  - `stall`=1 while the head is valid in WAIT_BR.
- Undefined:
  - The WAIT_BR state and `br_resolve` are unused.
  - BR is issued like ALU, and instructions after a `bne` issue back-to-back.

## Test plan
- Reset, then push 0x01095020 (add) with all frees high → `issue_valid` one cycle later, `issue_class`=0, `issue_instr`=0x01095020.
- Push 4 words with `rob_free`=0 → `fetch_ready`=0 after the 4th push, `stall`=1 throughout. Raise `rob_free` → 4 consecutive issues in order, then EMPTY.
- Head 0x71095002 (mul) with `mul_free`=0 and `alu_free`=1 → no issue while `mul_free`=0. The following add does not bypass it (in-order issue).
- Push 0xFC000000 (illegal), then an add → no strobe for the illegal word; the add issues one cycle later.
- With `ISSUE_BNE_BLOCK_EN`: push 0x15090003 (bne) then 3 adds → BR issues, adds stall. Pulse `br_resolve` → the adds issue on the following cycles. Without the macro → the adds issue back-to-back.
- With 3 entries queued, assert `flush` → count=0, no `issue_valid` that cycle, `fetch_ready`=1 on the next cycle. Assert `rst_n`=0 mid-stream → all outputs reach their reset values immediately.
